// File: rtl/hough_pixel_scanner_pkg.sv
// Shared types and widths for the Hough pixel scanner: FSM state encoding,
// ROI select values and output field widths.
package hough_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HT_RST,
    S_WAIT_RST,
    S_FETCH,
    S_WAIT_DATA,
    S_CLEAR,
    S_VOTE,
    S_ADVANCE,
    S_FINISH
  } state_e;

  localparam logic ROI_L = 1'b0;
  localparam logic ROI_R = 1'b1;

  localparam int COORD_W = 12;
  localparam int VOTE_W  = 16;

endpackage

// File: rtl/hough_pixel_scanner_if.sv
// Bus between the pixel scanner, the edge-image BRAM and the Hough voting stage.
// master = scanner side, slave = BRAM/Hough/control side.
interface hough_pixel_scanner_if #(
  parameter int ADDR_W = 17
);

  logic                         start;
  logic                         roi_sel;
  logic [ADDR_W-1:0]            img_addr;
  logic                         img_data;
  logic                         ht_reset;
  logic                         ht_reset_complete;
  logic                         ht_roi;
  logic                         ht_pixel;
  logic [hough_pkg::COORD_W-1:0] ht_x;
  logic [hough_pkg::COORD_W-1:0] ht_y;
  logic                         ht_clear;
  logic                         ht_enable;
  logic                         ht_done;
  logic                         busy;
  logic                         frame_done;
  logic [hough_pkg::VOTE_W-1:0] vote_count;

  modport master (
    input  start, roi_sel, img_data, ht_reset_complete, ht_done,
    output img_addr, ht_reset, ht_roi, ht_pixel, ht_x, ht_y,
           ht_clear, ht_enable, busy, frame_done, vote_count
  );

  modport slave (
    output start, roi_sel, img_data, ht_reset_complete, ht_done,
    input  img_addr, ht_reset, ht_roi, ht_pixel, ht_x, ht_y,
           ht_clear, ht_enable, busy, frame_done, vote_count
  );

endinterface

// File: rtl/hough_pixel_scanner_roi_addr_gen.sv
// ROI raster counters: x_rel/y_rel and an incrementally stepped row base,
// giving the current and next edge-BRAM address without a multiplier.
module roi_addr_gen
  import hough_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ROI_Y0 = 120,
  parameter int ADDR_W = 17
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_init,
  input  logic               i_adv,
  input  logic               i_roi,
  output logic [COORD_W-1:0] o_x_rel,
  output logic [COORD_W-1:0] o_y_rel,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [ADDR_W-1:0]  o_addr_nxt,
  output logic               o_last
);

  localparam int                 HALF_W = IMG_W / 2;
  localparam int                 ROI_H  = IMG_H - ROI_Y0;
  localparam logic [ADDR_W-1:0]  BASE0  = ADDR_W'(ROI_Y0 * IMG_W);
  localparam logic [ADDR_W-1:0]  PITCH  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]  X0_R   = ADDR_W'(HALF_W);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(HALF_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROI_H - 1);

  logic [COORD_W-1:0] r_x_rel;
  logic [COORD_W-1:0] r_y_rel;
  logic [ADDR_W-1:0]  r_row_base;
  logic               w_x_wrap;
  logic [ADDR_W-1:0]  w_x0;

  assign w_x_wrap   = (r_x_rel == X_LAST);
  assign w_x0       = (i_roi == ROI_R) ? X0_R : '0;
  assign o_addr     = r_row_base + w_x0 + ADDR_W'(r_x_rel);
  // Address of the pixel the next ADVANCE moves to, so it can be loaded on that same edge
  assign o_addr_nxt = w_x_wrap ? (r_row_base + PITCH + w_x0) : (o_addr + 1'b1);
  assign o_last     = w_x_wrap && (r_y_rel == Y_LAST);
  assign o_x_rel    = r_x_rel;
  assign o_y_rel    = r_y_rel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x_rel    <= '0;
      r_y_rel    <= '0;
      r_row_base <= BASE0;
    end else if (i_init) begin
      r_x_rel    <= '0;
      r_y_rel    <= '0;
      r_row_base <= BASE0;
    end else if (i_adv) begin
      if (w_x_wrap) begin
        r_x_rel    <= '0;
        r_y_rel    <= r_y_rel + 1'b1;
        r_row_base <= r_row_base + PITCH;
      end else begin
        r_x_rel <= r_x_rel + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hough_pixel_scanner.sv
// Per-ROI raster scanner feeding set edge pixels to the Hough voting stage,
// with accumulator reset before the scan and a frame_done pulse after it.
module hough_pixel_scanner
  import hough_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ROI_Y0 = 120,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset_n,
  hough_pixel_scanner_if.master bus
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_rst_first;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               r_roi;
  logic [ADDR_W-1:0]  r_img_addr;
  logic               r_ht_pixel;
  logic [COORD_W-1:0] r_ht_x;
  logic [COORD_W-1:0] r_ht_y;
  logic [VOTE_W-1:0]  r_vote_count;

  logic               w_accept;
  logic               w_load_cur;
  logic               w_load_nxt;
  logic               w_hit;
  logic               w_vote;
  logic               w_adv;
  logic               w_finish;
  logic               w_lat_done;
  logic [COORD_W-1:0] w_x_rel;
  logic [COORD_W-1:0] w_y_rel;
  logic [ADDR_W-1:0]  w_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic               w_last;

  function automatic logic [VOTE_W-1:0] sat_inc(input logic [VOTE_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  roi_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ROI_Y0 (ROI_Y0),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk      (CLK100MHZ),
    .i_rst_n    (reset_n),
    .i_init     (w_accept),
    .i_adv      (w_adv),
    .i_roi      (r_roi),
    .o_x_rel    (w_x_rel),
    .o_y_rel    (w_y_rel),
    .o_addr     (w_addr),
    .o_addr_nxt (w_addr_nxt),
    .o_last     (w_last)
  );

  assign w_lat_done = (r_lat_cnt == LAT_W'(RD_LAT - 1));

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_cur  = 1'b0;
    w_load_nxt  = 1'b0;
    w_hit       = 1'b0;
    w_vote      = 1'b0;
    w_adv       = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_HT_RST;
        end
      end
      S_HT_RST:   w_state_nxt = S_WAIT_RST;
      // complete is still high from the previous frame on the first cycle here
      S_WAIT_RST: begin
        if (!r_rst_first && bus.ht_reset_complete) begin
          w_load_cur  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH:    w_state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (w_lat_done) begin
          w_hit       = bus.img_data;
          w_state_nxt = bus.img_data ? S_CLEAR : S_ADVANCE;
        end
      end
      S_CLEAR:    w_state_nxt = S_VOTE;
      S_VOTE: begin
        if (bus.ht_done) begin
          w_vote      = 1'b1;
          w_state_nxt = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        w_adv = 1'b1;
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_FINISH;
        end else begin
          w_load_nxt  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FINISH:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_first  <= 1'b0;
      r_lat_cnt    <= '0;
      r_roi        <= 1'b0;
      r_img_addr   <= '0;
      r_ht_pixel   <= 1'b0;
      r_ht_x       <= '0;
      r_ht_y       <= '0;
      r_vote_count <= '0;
    end else begin
      r_rst_first <= (r_state == S_HT_RST);
      r_lat_cnt   <= (r_state == S_WAIT_DATA) ? r_lat_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_roi        <= bus.roi_sel;
        r_vote_count <= '0;
      end else if (w_vote) begin
        r_vote_count <= sat_inc(r_vote_count);
      end
      if (w_load_cur) begin
        r_img_addr <= w_addr;
      end else if (w_load_nxt) begin
        r_img_addr <= w_addr_nxt;
      end
      if (w_hit) begin
        r_ht_pixel <= 1'b1;
        r_ht_x     <= w_x_rel;
        r_ht_y     <= w_y_rel;
      end else if (w_finish) begin
        r_ht_pixel <= 1'b0;
      end
    end
  end

  assign bus.img_addr   = r_img_addr;
  assign bus.ht_reset   = (r_state == S_HT_RST);
  assign bus.ht_roi     = r_roi;
  assign bus.ht_pixel   = r_ht_pixel;
  assign bus.ht_x       = r_ht_x;
  assign bus.ht_y       = r_ht_y;
  assign bus.ht_clear   = (r_state == S_CLEAR);
  assign bus.ht_enable  = (r_state == S_VOTE);
  assign bus.busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign bus.frame_done = (r_state == S_FINISH);
  assign bus.vote_count = r_vote_count;

endmodule

// File: doc/hough_pixel_scanner.md
Name: hough_pixel_scanner

Overview:
- Upstream sequencer for the Hough transform stage. Per frame and per ROI, it raster-scans the binary edge-image BRAM over one ROI window.
- Each set pixel is presented to the Hough stage with its coordinates, followed by the clear/enable/done handshake. Zero pixels are skipped without a handshake.
- Before the scan it resets the Hough accumulator and waits for reset_complete. It signals frame_done when the window is exhausted, so m/b/lane_departure downstream are then valid.

Parameters:
- IMG_W, 320, image width in pixels (frame buffer row pitch).
- IMG_H, 240, image height in pixels.
- ROI_Y0, 120, first ROI row. Both ROIs span rows ROI_Y0..IMG_H-1.
- ADDR_W, 17, edge-BRAM address width.
- RD_LAT, 2, edge-BRAM read latency in cycles (address to data).

Ports:
- CLK100MHZ  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin scan of the selected ROI
- roi_sel  in  1  0=ROI_L (x 0..IMG_W/2-1), 1=ROI_R (x IMG_W/2..IMG_W-1); sampled on start
- img_addr  out  ADDR_W  edge-BRAM read address
- img_data  in  1  edge-BRAM read data (binary pixel)
- ht_reset  out  1  active-high reset pulse to the Hough stage
- ht_reset_complete  in  1  Hough accumulator cleared
- ht_roi  out  1  latched roi_sel, held stable through the scan
- ht_pixel  out  1  pixel value presented to the Hough stage
- ht_x  out  12  x relative to ROI origin
- ht_y  out  12  y relative to ROI_Y0
- ht_clear  out  1  one-cycle pulse: new coordinate ready
- ht_enable  out  1  held high while voting
- ht_done  in  1  Hough voting for the current coordinate finished
- busy  out  1  high from the accepted start until frame_done
- frame_done  out  1  one-cycle pulse at the end of the scan
- vote_count  out  16  number of set pixels handed to the Hough stage this scan; saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including img_addr, ht_x, ht_y, vote_count and ht_roi.
- States: IDLE, HT_RST, WAIT_RST, FETCH, WAIT_DATA, CLEAR, VOTE, ADVANCE, FINISH.
- IDLE:
  - start=1 latches roi_sel into ht_roi, zeroes vote_count, x_rel and y_rel, sets busy, goes to HT_RST.
  - start while busy is ignored.
- HT_RST: ht_reset=1 for exactly one cycle, then WAIT_RST.
- WAIT_RST: wait for ht_reset_complete=1. Ignore the cycle directly after HT_RST, because complete is still high from the previous frame. Then FETCH.
- Address generation:
  - img_addr = row_base + x0 + x_rel, where x0 = ht_roi ? IMG_W/2 : 0.
  - row_base starts at ROI_Y0*IMG_W (a constant) and is incremented by IMG_W per row. No multiplier.
- FETCH: drive img_addr for one cycle, then WAIT_DATA.
- WAIT_DATA: count RD_LAT cycles, then sample img_data.
  - img_data=0: go to ADVANCE. No clear/enable issued.
  - img_data=1: register ht_pixel=1, ht_x=x_rel, ht_y=y_rel, go to CLEAR.
- CLEAR: ht_clear=1 for one cycle with ht_enable=0; coordinates stable. Then VOTE.
- VOTE:
  - ht_enable=1, coordinates held.
  - On ht_done=1: deassert ht_enable in the same transition, vote_count+1 (saturating), go to ADVANCE.
  - ht_done is never sampled in the CLEAR cycle.
- ADVANCE:
  - x_rel+1. At x_rel=IMG_W/2-1, wrap x_rel to 0, y_rel+1, row_base+IMG_W.
  - At the last pixel (x_rel=IMG_W/2-1, y_rel=IMG_H-ROI_Y0-1) go to FINISH; otherwise FETCH.
- FINISH: frame_done=1 for one cycle, busy=0, ht_pixel=0. Return to IDLE. ht_roi, ht_x, ht_y and vote_count are held until the next start.
- Timing:
  - Zero-pixel cost: 2+RD_LAT cycles (FETCH, WAIT_DATA, ADVANCE).
  - Set-pixel cost: 4+RD_LAT cycles plus the VOTE duration.
  - ht_done arriving the same cycle VOTE is entered is honoured.
- Mid-operation reset_n assertion aborts immediately to the reset state. No frame_done is issued. A subsequent start re-resets the Hough stage.
- ht_roi must not change between start and frame_done. The Hough stage's theta mapping depends on it.

Decomposition:
- Shared package (hough_pkg): state encoding enum, ROI_L/ROI_R constants, coordinate width (12), vote_count width (16).
- One natural sub-module: roi_addr_gen, which holds the x_rel/y_rel/row_base counters, the wrap logic and the last-pixel flag. The FSM remains in the top.

Test Plan:
- All-zero image, ROI_L, RD_LAT=2 → one ht_reset pulse, zero ht_clear pulses, frame_done exactly 160*120*4 cycles after WAIT_RST exits, vote_count=0.
- Single set pixel at image (5,130), ROI_L → one ht_clear with ht_x=5, ht_y=10. ht_enable high until ht_done (model returns done after 70 cycles). vote_count=1.
- Single set pixel at image (165,239), ROI_R → ht_x=5, ht_y=119, ht_roi=1 stable throughout. Pixel is last-but-154 in scan order; frame_done follows the final address 239*320+319.
- ht_reset_complete held low for 500 cycles after ht_reset → no img_addr activity until it rises. Scan starts on the first cycle after it rises.
- start pulsed at cycle 50 of a busy scan, with roi_sel toggled → ignored; ht_roi unchanged; exactly one frame_done.
- reset_n asserted during VOTE → all outputs 0 asynchronously, no frame_done. A new start then completes a full scan correctly.
